// File: rtl/instr_loader.sv
// Boot-time program loader: encodes symbolic instruction beats into 9-bit words
// and writes them to instruction memory from address 0. Optional macro: LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_opcode,
  input  logic [2:0]    in_ra,
  input  logic [1:0]    in_rb,
  input  logic [4:0]    in_imm,
  input  logic          in_last,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [8:0]    im_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          err,
  output logic [AW:0]   count,
  output logic [8:0]    checksum
);

  localparam int unsigned CW        = AW + 1;
  localparam int unsigned WW        = 9;
  localparam int unsigned MAX_WORDS = 2 ** AW;

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  state_t        state, state_d;
  logic          in_ready_d, im_we_d, cpu_hold_d, done_d, err_d;
  logic [AW-1:0] im_addr_d;
  logic [WW-1:0] im_wdata_d;
  logic [CW-1:0] count_d;
  logic [4:0]    operand_c;
  logic          legal_c;
  logic [WW-1:0] word_c;
  logic          accept_c;
  logic          full_c;

  // Opcode classification and operand selection
  always_comb begin
    operand_c = 5'd0;
    legal_c   = 1'b1;
    unique case (in_opcode)
      4'b0001, 4'b0010, 4'b0111,
      4'b1000, 4'b1010, 4'b1011: operand_c = in_imm;
      4'b0000, 4'b0011, 4'b0100,
      4'b0101, 4'b0110, 4'b1100,
      4'b1101:                   operand_c = {in_ra, in_rb};
      4'b1111:                   operand_c = 5'd0;
      default:                   legal_c   = 1'b0;
    endcase
  end

  assign word_c   = {in_opcode, operand_c};
  assign accept_c = in_valid && in_ready && (state == LOAD);
  assign full_c   = (count == CW'(MAX_WORDS));

`ifdef LOADER_CHECKSUM_EN
  logic [WW-1:0] checksum_q, checksum_d;
  assign checksum = checksum_q;
`else
  assign checksum = WW'(0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      count      <= '0;
`ifdef LOADER_CHECKSUM_EN
      checksum_q <= '0;
`endif
    end else begin
      state      <= state_d;
      in_ready   <= in_ready_d;
      im_we      <= im_we_d;
      im_addr    <= im_addr_d;
      im_wdata   <= im_wdata_d;
      cpu_hold   <= cpu_hold_d;
      done       <= done_d;
      err        <= err_d;
      count      <= count_d;
`ifdef LOADER_CHECKSUM_EN
      checksum_q <= checksum_d;
`endif
    end
  end

  // Next state and registered-output values; done/cpu_hold release the cycle after the final write
  always_comb begin
    state_d    = state;
    in_ready_d = in_ready;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr;
    im_wdata_d = im_wdata;
    cpu_hold_d = cpu_hold;
    done_d     = done;
    err_d      = err;
    count_d    = count;
`ifdef LOADER_CHECKSUM_EN
    checksum_d = checksum_q;
`endif
    unique case (state)
      LOAD: begin
        in_ready_d = 1'b1;
        cpu_hold_d = 1'b1;
        if (accept_c) begin
          if (!legal_c || full_c) begin
            state_d    = ERR;
            err_d      = 1'b1;
            in_ready_d = 1'b0;
          end else begin
            im_we_d    = 1'b1;
            im_addr_d  = count[AW-1:0];
            im_wdata_d = word_c;
            count_d    = count + CW'(1);
`ifdef LOADER_CHECKSUM_EN
            checksum_d = checksum_q ^ word_c;
`endif
            if (in_last) begin
              state_d    = DONE;
              in_ready_d = 1'b0;
            end
          end
        end
      end
      default: begin
        in_ready_d = 1'b0;
        cpu_hold_d = (state != DONE);
        done_d     = (state == DONE);
        err_d      = (state == ERR);
        if (start) begin
          state_d    = LOAD;
          in_ready_d = 1'b1;
          cpu_hold_d = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          count_d    = '0;
          im_addr_d  = '0;
`ifdef LOADER_CHECKSUM_EN
          checksum_d = '0;
`endif
        end
      end
    endcase
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed testbench for instr_loader (AW=2 so the overflow boundary is reachable).
module tb_instr_loader;

  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, in_last;
  logic [3:0]    in_opcode;
  logic [2:0]    in_ra;
  logic [1:0]    in_rb;
  logic [4:0]    in_imm;
  logic          in_ready, im_we, cpu_hold, done, err;
  logic [AW-1:0] im_addr;
  logic [8:0]    im_wdata, checksum;
  logic [AW:0]   count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [8:0]    wd_q[$];
  logic [AW-1:0] wa_q[$];
  time           wt_q[$];

  instr_loader #(.AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm), .in_last(in_last),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .cpu_hold(cpu_hold),
    .done(done), .err(err), .count(count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // Record every memory write seen on the falling edge
  always @(negedge clk) begin
    if (reset && im_we) begin
      wd_q.push_back(im_wdata);
      wa_q.push_back(im_addr);
      wt_q.push_back($time);
    end
  end

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_opcode = 4'h0; in_ra = 3'd0; in_rb = 2'd0; in_imm = 5'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    wd_q.delete(); wa_q.delete(); wt_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic beat(input logic [3:0] op, input logic [2:0] ra, input logic [1:0] rb,
                      input logic [4:0] imm, input logic last);
    bit ok = 0;
    in_opcode = op; in_ra = ra; in_rb = rb; in_imm = imm; in_last = last;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_last = 1'b0;
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL beat_accept: in_ready never high for opcode %h", op); end
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err, count, checksum} !==
        {1'b0, 1'b0, 2'd0, 9'd0, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0}) begin
      n_fail++;
      $display("FAIL reset_values: rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b cnt=%0d cs=%h want 0 0 0 000 1 0 0 0 000",
               in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err, count, checksum);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    pulse_start();
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", in_ready); end
    beat(4'b0000, 3'd3, 2'd1, 5'd0, 1'b0);
    beat(4'b1011, 3'd0, 2'd0, 5'd17, 1'b1);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (wd_q.size() !== 2) begin n_fail++; $display("FAIL basic_nwrites: got %0d want 2", wd_q.size()); end
    else begin
      n_cmp++;
      if ({wa_q[0], wd_q[0], wa_q[1], wd_q[1]} !== {2'd0, 9'h00D, 2'd1, 9'h171}) begin
        n_fail++;
        $display("FAIL basic_writes: got %h@%0d %h@%0d want 00d@0 171@1", wd_q[0], wa_q[0], wd_q[1], wa_q[1]);
      end
    end
    n_cmp++;
    if ({count, done, cpu_hold, in_ready, err} !== {3'd2, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_status: cnt=%0d done=%b hold=%b rdy=%b err=%b want 2 1 0 0 0", count, done, cpu_hold, in_ready, err);
    end
`ifdef LOADER_CHECKSUM_EN
    n_cmp++;
    if (checksum !== 9'h17C) begin n_fail++; $display("FAIL basic_checksum: got %h want 17c", checksum); end
`endif
  endtask

  task automatic test_nop();
    logic [8:0] exp_cs;
    int n;
    do_reset();
    pulse_start();
    beat(4'b1111, 3'd7, 2'd3, 5'h1F, 1'b1);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (wd_q.size() !== 1 || wd_q[0] !== 9'h1E0) begin
      n_fail++; $display("FAIL nop_write: n=%0d word=%h want 1 1e0", wd_q.size(), wd_q.size() > 0 ? wd_q[0] : 9'h0);
    end
`ifdef LOADER_CHECKSUM_EN
    exp_cs = 9'h1E0;
`else
    exp_cs = 9'h000;
`endif
    n_cmp++;
    if (checksum !== exp_cs) begin n_fail++; $display("FAIL nop_checksum: got %h want %h", checksum, exp_cs); end
    n_cmp++;
    if ({count, done} !== {3'd1, 1'b1}) begin n_fail++; $display("FAIL nop_single: cnt=%0d done=%b want 1 1", count, done); end
    // Beats offered while DONE must be ignored
    n = wd_q.size();
    in_opcode = 4'b0000; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (wd_q.size() !== n || done !== 1'b1 || count !== 3'd1) begin
      n_fail++; $display("FAIL done_ignore: writes=%0d done=%b cnt=%0d want %0d 1 1", wd_q.size(), done, count, n);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    pulse_start();
    beat(4'b0000, 3'd3, 2'd1, 5'd0, 1'b0);
    beat(4'b1001, 3'd0, 2'd0, 5'd4, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (wd_q.size() !== 1 || wd_q[0] !== 9'h00D) begin
      n_fail++; $display("FAIL illegal_writes: n=%0d want 1 (00d)", wd_q.size());
    end
    n_cmp++;
    if ({err, cpu_hold, in_ready, done, count} !== {1'b1, 1'b1, 1'b0, 1'b0, 3'd1}) begin
      n_fail++; $display("FAIL illegal_status: err=%b hold=%b rdy=%b done=%b cnt=%0d want 1 1 0 0 1", err, cpu_hold, in_ready, done, count);
    end
    pulse_start();
    n_cmp++;
    if ({err, count, in_ready, cpu_hold} !== {1'b0, 3'd0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL illegal_restart: err=%b cnt=%0d rdy=%b hold=%b want 0 0 1 1", err, count, in_ready, cpu_hold);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    pulse_start();
    for (int i = 0; i < 5; i++) beat(4'b0111, 3'd0, 2'd0, 5'(i), 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (wd_q.size() !== 4) begin n_fail++; $display("FAIL ovf_nwrites: got %0d want 4", wd_q.size()); end
    else begin
      ok = 1;
      for (int i = 0; i < 4; i++)
        if (wa_q[i] !== AW'(i) || wd_q[i] !== 9'h0E0 + 9'(i)) ok = 0;
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL ovf_writes: got %h@%0d .. %h@%0d want 0e0@0 .. 0e3@3", wd_q[0], wa_q[0], wd_q[3], wa_q[3]); end
    end
    n_cmp++;
    if ({err, count, cpu_hold, in_ready, done} !== {1'b1, 3'd4, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL ovf_status: err=%b cnt=%0d hold=%b rdy=%b done=%b want 1 4 1 0 0", err, count, cpu_hold, in_ready, done);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pulse_start();
    beat(4'b0001, 3'd0, 2'd0, 5'd5, 1'b0);
    beat(4'b1100, 3'd2, 2'd3, 5'd0, 1'b0);
    beat(4'b1010, 3'd0, 2'd0, 5'd31, 1'b0);
    n_cmp++;
    if ({im_we, im_addr, im_wdata, count} !== {1'b1, 2'd2, 9'h15F, 3'd3}) begin
      n_fail++; $display("FAIL b2b_third: we=%b a=%0d d=%h cnt=%0d want 1 2 15f 3", im_we, im_addr, im_wdata, count);
    end
    n_cmp++;
    if (wd_q.size() !== 2) begin n_fail++; $display("FAIL b2b_nwrites: got %0d want 2", wd_q.size()); end
    else begin
      n_cmp++;
      if ({wa_q[0], wd_q[0], wa_q[1], wd_q[1]} !== {2'd0, 9'h025, 2'd1, 9'h18B} ||
          wt_q[1] - wt_q[0] != 10 || $time - wt_q[1] > 10) begin
        n_fail++; $display("FAIL b2b_writes: got %h@%0d %h@%0d (t %0t %0t) want 025@0 18b@1 consecutive",
                           wd_q[0], wa_q[0], wd_q[1], wa_q[1], wt_q[0], wt_q[1]);
      end
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err, count, checksum} !==
        {1'b0, 1'b0, 2'd0, 9'd0, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0}) begin
      n_fail++;
      $display("FAIL midload_reset: rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b cnt=%0d cs=%h want reset values",
               in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err, count, checksum);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_basic();
    test_nop();
    test_illegal();
    test_overflow();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Boot-time program loader; the writer side of the 9-bit machine-code path the core's control decoder reads.
- Accepts symbolic instruction beats (opcode plus operand fields) over a valid/ready handshake and encodes each into a 9-bit machine word.
- Writes words sequentially into instruction memory from address 0.
- Holds the core in hold until a complete, legal program is loaded.

Parameters:
AW, 10, instruction memory address width; capacity MAX_WORDS = 2**AW.

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begin a new load at address 0
in_valid  in  1  beat valid
in_ready  out  1  loader can accept a beat
in_opcode  in  4  instruction opcode
in_ra  in  3  R-format destination/first register
in_rb  in  2  R-format source register
in_imm  in  5  I-format immediate
in_last  in  1  final beat of program
im_we  out  1  instruction memory write strobe
im_addr  out  AW  write address
im_wdata  out  9  encoded machine word
cpu_hold  out  1  1 = core held in hold (not fetching)
done  out  1  program loaded successfully
err  out  1  sticky load error
count  out  AW+1  words written this load
checksum  out  9  running checksum (see Optional Feature)

Behaviour:
- Reset (reset=0, async): state IDLE, in_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_hold=1, done=0, err=0, count=0, checksum=0.
- Encoding: im_wdata[8:5]=opcode; im_wdata[4:0]=operand.
  - I-format opcodes 0001 SLL, 0010 SLR, 0111 ADDi, 1000 BNE, 1010 BEQ, 1011 MOVi: operand=in_imm.
  - R-format opcodes 0000, 0011, 0100, 0101, 0110, 1100 SW, 1101 LW: operand={in_ra,in_rb}.
  - 1111 NOP: operand forced to 00000.
  - 1001 and 1110 are illegal.
- Handshake: beat accepted on a cycle where in_valid && in_ready. in_valid/fields may change only after acceptance.
- States:
  - IDLE: in_ready=0, cpu_hold=1. start -> LOAD; clears count, err, done, checksum; im_addr=0.
  - LOAD: in_ready=1 while count < MAX_WORDS.
    - On accept of a legal opcode: next cycle im_we=1 (one cycle), im_addr=count, im_wdata=encoded word; count increments that same cycle. Back-to-back beats are allowed, one write per cycle.
    - Accept with in_last: after the write, go to DONE.
    - Accept with an illegal opcode: no write; go to ERR.
    - Accept when count==MAX_WORDS: no write, overflow; go to ERR. in_ready stays 1 so the overflow beat is consumed.
  - DONE: done=1, cpu_hold=0, in_ready=0. start -> LOAD (done cleared, cpu_hold=1).
  - ERR: err=1, cpu_hold=1, in_ready=0. Only start (-> LOAD) or reset exits.
- start while in LOAD: ignored.
- in_valid while not in LOAD: ignored, no state change.
- Reset mid-load: immediate return to reset values. Partial memory contents are not cleared; cpu_hold=1 prevents execution.
- A single-beat program (in_last on the first beat) is legal: count=1, done.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- Defined: checksum = XOR of all im_wdata written this load, updated in the im_we cycle, cleared on start and reset.
- Undefined: checksum is constant 0 and no checksum logic is built.

Test Plan:
- reset low, then high; start; beats ADD ra=3 rb=1, then MOVi imm=17 with in_last -> writes 9'h00D @0, then 9'h171 @1. count=2, done=1, cpu_hold=0.
- NOP beat with in_imm=5'h1F, in_last -> write 9'h1E0; checksum=9'h1E0 with LOADER_CHECKSUM_EN, 0 without.
- Beats ADD(3,1), then opcode 1001 -> only 9'h00D written; err=1, cpu_hold=1, in_ready=0. Then start -> err=0, count=0, in LOAD.
- AW=2, five legal beats with no in_last -> addresses 0..3 written, fifth beat consumed with no write, err=1, count=4.
- Start, then continuous in_valid for three beats -> im_we high for three consecutive cycles, addresses 0,1,2. Then reset pulled low mid-stream -> all outputs at reset values the same cycle.
